regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-back arbiter: one holding entry per source (ALU, load),
// round-robin grant into a single register-file write port, with an end-of-program drain.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | accepting offers from both requesters, granting full entries
// DRAIN  | offers refused, remaining held entries written out
// DONE   | drain finished, call_for_print pulsed once; held until reset
module regfile_write_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [BUS_DATA_WIDTH-1:0] alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [BUS_DATA_WIDTH-1:0] mem_data,
    output logic                      mem_ready,
    input  logic                      end_of_cycle,
    output logic                      rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [BUS_DATA_WIDTH-1:0] rf_wdata,
    output logic                      call_for_print,
    output logic [31:0]               write_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    state_t                    state_q;
    logic                      last_grant_q;

    logic                      alu_full_q;
    logic [REG_ADDR_WIDTH-1:0] alu_rd_q;
    logic [BUS_DATA_WIDTH-1:0] alu_data_q;
    logic                      mem_full_q;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
    logic [BUS_DATA_WIDTH-1:0] mem_data_q;

    logic                      rf_write_en_q;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q;
    logic [BUS_DATA_WIDTH-1:0] rf_wdata_q;
    logic                      call_for_print_q;
    logic [31:0]               write_count_q;

    logic                      grant_alu;
    logic                      grant_mem;
    logic                      grant_any;
    logic [REG_ADDR_WIDTH-1:0] grant_rd;
    logic [BUS_DATA_WIDTH-1:0] grant_data;
    logic                      run_ok;
    logic                      alu_accept;
    logic                      mem_accept;

    // ALU wins when alone or when the load path was served last.
    always_comb begin
        grant_alu  = alu_full_q && (!mem_full_q || (last_grant_q == GRANT_MEM));
        grant_mem  = mem_full_q && !grant_alu;
        grant_any  = grant_alu || grant_mem;
        grant_rd   = grant_alu ? alu_rd_q   : mem_rd_q;
        grant_data = grant_alu ? alu_data_q : mem_data_q;
    end

    // rst_n gates ready so a requester never sees an accept while reset is held.
    assign run_ok     = rst_n && (state_q == ST_RUN);
    assign alu_ready  = run_ok && (!alu_full_q || grant_alu);
    assign mem_ready  = run_ok && (!mem_full_q || grant_mem);
    assign alu_accept = alu_valid && alu_ready;
    assign mem_accept = mem_valid && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            last_grant_q     <= GRANT_MEM;
            alu_full_q       <= 1'b0;
            alu_rd_q         <= '0;
            alu_data_q       <= '0;
            mem_full_q       <= 1'b0;
            mem_rd_q         <= '0;
            mem_data_q       <= '0;
            rf_write_en_q    <= 1'b0;
            rf_waddr_q       <= '0;
            rf_wdata_q       <= '0;
            call_for_print_q <= 1'b0;
            write_count_q    <= '0;
        end else begin
            if (alu_accept) begin
                alu_full_q <= 1'b1;
                alu_rd_q   <= alu_rd;
                alu_data_q <= alu_data;
            end else if (grant_alu) begin
                alu_full_q <= 1'b0;
            end

            if (mem_accept) begin
                mem_full_q <= 1'b1;
                mem_rd_q   <= mem_rd;
                mem_data_q <= mem_data;
            end else if (grant_mem) begin
                mem_full_q <= 1'b0;
            end

            if (grant_any) begin
                last_grant_q <= grant_mem ? GRANT_MEM : GRANT_ALU;
            end

            // Writes to x0 are consumed but never reach the register file.
            rf_write_en_q <= 1'b0;
            if (grant_any && (grant_rd != '0)) begin
                rf_write_en_q <= 1'b1;
                rf_waddr_q    <= grant_rd;
                rf_wdata_q    <= grant_data;
                write_count_q <= write_count_q + 32'd1;
            end

            call_for_print_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (end_of_cycle) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!alu_full_q && !mem_full_q) begin
                        state_q          <= ST_DONE;
                        call_for_print_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign rf_write_en    = rf_write_en_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign call_for_print = call_for_print_q;
    assign write_count    = write_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: tie arbitration, latency, x0 discard,
// back-to-back throughput, end-of-program drain and reset with pending entries.
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          end_of_cycle;
    logic          rf_write_en;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          call_for_print;
    logic [31:0]   write_count;

    int vectors;
    int miscompares;

    regfile_write_arbiter #(
        .BUS_DATA_WIDTH(DW),
        .REG_ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .end_of_cycle  (end_of_cycle),
        .rf_write_en   (rf_write_en),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .call_for_print(call_for_print),
        .write_count   (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid    = 1'b0;
        alu_rd       = '0;
        alu_data     = '0;
        mem_valid    = 1'b0;
        mem_rd       = '0;
        mem_data     = '0;
        end_of_cycle = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_we", rf_write_en, 0);
        check("rst_count", write_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_waddr", rf_waddr, 0);
        check("reset_wdata", rf_wdata, 0);
        check("reset_cfp", call_for_print, 0);
        apply_reset();
        check("run_alu_ready", alu_ready, 1);
        check("run_mem_ready", mem_ready, 1);

        // tie from reset: ALU first, then MEM
        alu_valid = 1; alu_rd = 1; alu_data = 64'hA;
        mem_valid = 1; mem_rd = 2; mem_data = 64'hB;
        #1;
        check("tie_alu_ready", alu_ready, 1);
        check("tie_mem_ready", mem_ready, 1);
        tick();
        idle_inputs();
        check("tie_no_write_yet", rf_write_en, 0);
        tick();
        check("tie1_we", rf_write_en, 1);
        check("tie1_waddr", rf_waddr, 1);
        check("tie1_wdata", rf_wdata, 64'hA);
        check("tie1_count", write_count, 1);
        tick();
        check("tie2_we", rf_write_en, 1);
        check("tie2_waddr", rf_waddr, 2);
        check("tie2_wdata", rf_wdata, 64'hB);
        check("tie2_count", write_count, 2);
        // lone ALU write makes ALU the last grant, so the next tie goes to MEM
        alu_valid = 1; alu_rd = 4; alu_data = 64'h44;
        tick();
        idle_inputs();
        tick();
        check("solo_waddr", rf_waddr, 4);
        check("solo_count", write_count, 3);
        alu_valid = 1; alu_rd = 5; alu_data = 64'hC;
        mem_valid = 1; mem_rd = 6; mem_data = 64'hD;
        tick();
        idle_inputs();
        tick();
        check("tie3_waddr_mem", rf_waddr, 6);
        check("tie3_wdata_mem", rf_wdata, 64'hD);
        tick();
        check("tie4_waddr_alu", rf_waddr, 5);
        check("tie4_wdata_alu", rf_wdata, 64'hC);
        check("tie4_count", write_count, 5);
        tick();
        check("tie_idle_we", rf_write_en, 0);
        check("tie_idle_hold", rf_waddr, 5);

        // single ALU write latency
        apply_reset();
        alu_valid = 1; alu_rd = 3; alu_data = 64'h55;
        #1;
        check("single_ready", alu_ready, 1);
        tick();
        idle_inputs();
        check("single_lat1_we", rf_write_en, 0);
        tick();
        check("single_we", rf_write_en, 1);
        check("single_waddr", rf_waddr, 3);
        check("single_wdata", rf_wdata, 64'h55);
        check("single_count", write_count, 1);
        tick();
        check("single_we_drop", rf_write_en, 0);
        check("single_waddr_hold", rf_waddr, 3);

        // x0 discard
        mem_valid = 1; mem_rd = 0; mem_data = 64'hFF;
        #1;
        check("x0_ready", mem_ready, 1);
        tick();
        idle_inputs();
        tick();
        check("x0_we", rf_write_en, 0);
        check("x0_count", write_count, 1);
        check("x0_waddr_hold", rf_waddr, 3);
        tick();
        check("x0_we_after", rf_write_en, 0);
        check("x0_mem_ready_after", mem_ready, 1);

        // back-to-back ALU stream
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = AW'(4 + i); alu_data = 64'h100 + 64'(i);
            #1;
            check("b2b_ready", alu_ready, 1);
            tick();
            if (i > 0) begin
                check("b2b_we", rf_write_en, 1);
                check("b2b_waddr", rf_waddr, 64'(3 + i));
            end
        end
        idle_inputs();
        tick();
        check("b2b_last_we", rf_write_en, 1);
        check("b2b_last_waddr", rf_waddr, 7);
        check("b2b_last_wdata", rf_wdata, 64'h103);
        check("b2b_count", write_count, 4);
        tick();
        check("b2b_we_drop", rf_write_en, 0);

        // drain with an ALU offer on the end_of_cycle edge and MEM already held
        mem_valid = 1; mem_rd = 2; mem_data = 64'h22;
        tick();
        idle_inputs();
        alu_valid = 1; alu_rd = 7; alu_data = 64'h77; end_of_cycle = 1;
        #1;
        check("eoc_alu_ready", alu_ready, 1);
        tick();
        end_of_cycle = 0;
        alu_rd = 9; alu_data = 64'h99;
        mem_valid = 1; mem_rd = 10; mem_data = 64'hAA;
        #1;
        check("drain_mem_we", rf_write_en, 1);
        check("drain_mem_waddr", rf_waddr, 2);
        check("drain_alu_ready", alu_ready, 0);
        check("drain_mem_ready", mem_ready, 0);
        check("drain_cfp0", call_for_print, 0);
        tick();
        check("drain_alu_we", rf_write_en, 1);
        check("drain_alu_waddr", rf_waddr, 7);
        check("drain_alu_wdata", rf_wdata, 64'h77);
        check("drain_count", write_count, 6);
        check("drain_cfp1", call_for_print, 0);
        check("drain_ready2", alu_ready, 0);
        tick();
        check("done_cfp", call_for_print, 1);
        check("done_we", rf_write_en, 0);
        tick();
        check("done_cfp_drop", call_for_print, 0);
        end_of_cycle = 1;
        tick();
        tick();
        end_of_cycle = 0;
        tick();
        check("done_no_pulse", call_for_print, 0);
        check("done_mem_ready", mem_ready, 0);
        check("done_count", write_count, 6);
        idle_inputs();

        // reset with both entries full
        apply_reset();
        alu_valid = 1; alu_rd = 8; alu_data = 64'h88;
        mem_valid = 1; mem_rd = 9; mem_data = 64'h99;
        tick();
        mem_valid = 0;
        alu_rd = 10; alu_data = 64'hAA;
        tick();
        alu_valid = 0;
        check("pre_rst_we", rf_write_en, 1);
        check("pre_rst_waddr", rf_waddr, 8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", rf_write_en, 0);
        check("mid_rst_alu_ready", alu_ready, 0);
        check("mid_rst_mem_ready", mem_ready, 0);
        check("mid_rst_count", write_count, 0);
        check("mid_rst_waddr", rf_waddr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_we", rf_write_en, 0);
        tick();
        check("post_rst_we2", rf_write_en, 0);
        check("post_rst_count", write_count, 0);
        check("post_rst_alu_ready", alu_ready, 1);
        check("post_rst_mem_ready", mem_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
